// File: rtl/chan_mux_seq.sv
`default_nettype none
// ============================================================================
// Module      : chan_mux_seq
// Description : N_CH-way channel multiplexer with a one-beat registered
//               output slot and valid/ready handshake. Manual mode
//               continuously forwards the channel chosen by sel. Scan mode,
//               launched by a start pulse, emits every channel exactly once
//               in order 0..N_CH-1 and pulses done when the last beat is taken.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               data_in   - flattened channels, channel k at [k*WIDTH +: WIDTH]
//               sel       - manual channel select (clamped to N_CH-1)
//               mode      - 0 manual, 1 scan (sampled in IDLE only)
//               start     - scan request (honoured in IDLE with mode=1)
//               out_data  - registered channel data
//               out_ch    - channel index of out_data
//               out_valid - output slot holds a beat
//               out_ready - downstream accepts the beat
//               busy      - scan in progress
//               done      - one-cycle pulse after the final scan beat is taken
// Revision    : 1.0 - initial release
// ============================================================================
module chan_mux_seq #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   data_in,
  input  logic [SELW-1:0]         sel,
  input  logic                    mode,
  input  logic                    start,
  output logic [WIDTH-1:0]        out_data,
  output logic [SELW-1:0]         out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [0:0]      ST_IDLE = 1'b0;
  localparam logic [0:0]      ST_SCAN = 1'b1;
  localparam logic [SELW-1:0] LAST_CH = SELW'(N_CH - 1);

  logic [0:0]      r_state;
  logic [SELW-1:0] r_ch_cnt;
  logic            r_all_loaded;   // last channel of the scan already loaded
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0] r_out_ch;
  logic            r_out_valid;
  logic            r_done;

  logic [WIDTH-1:0] w_ch_data [N_CH];
  logic [SELW-1:0]  w_sel_clamped;
  logic             w_slot_free;
  logic             w_load_manual;
  logic             w_load_scan;
  logic             w_load;
  logic [SELW-1:0]  w_load_idx;
  logic             w_scan_end;

  // Unpack the flat bus so channel selection is a plain array index.
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_ch_data[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Out-of-range selects only exist when N_CH is not a power of two.
  if (N_CH == (1 << SELW)) begin : g_sel_direct
    assign w_sel_clamped = sel;
  end else begin : g_sel_clamp
    assign w_sel_clamped = (sel > LAST_CH) ? LAST_CH : sel;
  end

  always_comb begin
    w_slot_free   = !r_out_valid || out_ready;
    w_load_manual = (r_state == ST_IDLE) && !mode && w_slot_free;
    w_load_scan   = (r_state == ST_SCAN) && !r_all_loaded && w_slot_free;
    w_load        = w_load_manual || w_load_scan;
    w_load_idx    = (r_state == ST_SCAN) ? r_ch_cnt : w_sel_clamped;
    // With every channel loaded, the only beat left in the slot is the last one.
    w_scan_end    = (r_state == ST_SCAN) && r_all_loaded && r_out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ch_cnt     <= '0;
      r_all_loaded <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        r_out_data  <= w_ch_data[w_load_idx];
        r_out_ch    <= w_load_idx;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (mode && start) begin
            r_state      <= ST_SCAN;
            r_ch_cnt     <= '0;
            r_all_loaded <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_load_scan) begin
            // Hold the counter at the last channel instead of wrapping.
            if (r_ch_cnt == LAST_CH) begin
              r_all_loaded <= 1'b1;
            end else begin
              r_ch_cnt <= r_ch_cnt + SELW'(1);
            end
          end
          if (w_scan_end) begin
            r_state      <= ST_IDLE;
            r_ch_cnt     <= '0;
            r_all_loaded <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == ST_SCAN);
  assign done      = r_done;

endmodule
`default_nettype wire
